// File: rtl/mips_ss_pkg.sv
// Shared types and sizing for the superscalar MIPS register file slice.
// Data, tag and request bundles used by the rename and writeback paths.
package mips_ss_pkg;

    localparam int NUM_REGS  = 32;
    localparam int DATA_W    = 32;
    localparam int TAG_W     = 6;
    localparam int NUM_ISSUE = 4;
    localparam int NUM_RD    = 8;
    localparam int NUM_WB    = 2;
    localparam int AW        = $clog2(NUM_REGS);
    localparam int SW        = $clog2(NUM_ISSUE) + 1;
    localparam int CW        = $clog2(NUM_REGS) + 1;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [AW-1:0]     reg_idx_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam tag_t TAG_READY = '0;

    typedef struct packed {
        logic     valid;
        reg_idx_t addr;
        tag_t     tag;
    } rn_req_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t addr;
        tag_t     tag;
        data_t    data;
    } wb_req_t;

endpackage

// File: rtl/tagged_regfile_mp_if.sv
// Issue/writeback bus of the tagged register file.
// master = decode/issue side, slave = register file.
interface tagged_regfile_mp_if import mips_ss_pkg::*;;

    logic                        flush;
    logic     [NUM_WB-1:0]       wb_valid;
    reg_idx_t [NUM_WB-1:0]       wb_addr;
    tag_t     [NUM_WB-1:0]       wb_tag;
    data_t    [NUM_WB-1:0]       wb_data;
    logic     [NUM_ISSUE-1:0]    rn_valid;
    reg_idx_t [NUM_ISSUE-1:0]    rn_addr;
    tag_t     [NUM_ISSUE-1:0]    rn_tag;
    reg_idx_t [NUM_RD-1:0]       rd_addr;
    logic     [NUM_RD-1:0][SW-1:0] rd_slot;
    data_t    [NUM_RD-1:0]       rd_data;
    tag_t     [NUM_RD-1:0]       rd_tag;
    logic     [CW-1:0]           pending;
    logic                        all_clear;

    modport master (
        output flush, wb_valid, wb_addr, wb_tag, wb_data,
        output rn_valid, rn_addr, rn_tag, rd_addr, rd_slot,
        input  rd_data, rd_tag, pending, all_clear
    );

    modport slave (
        input  flush, wb_valid, wb_addr, wb_tag, wb_data,
        input  rn_valid, rn_addr, rn_tag, rd_addr, rd_slot,
        output rd_data, rd_tag, pending, all_clear
    );

endinterface

// File: rtl/tagged_regfile_rdport.sv
// One read port: slot-ordered rename bypass, then tag-matched writeback bypass.
module tagged_regfile_rdport import mips_ss_pkg::*; (
    input  reg_idx_t      addr,
    input  logic [SW-1:0] slot,
    input  data_t         st_data,
    input  tag_t          st_tag,
    input  rn_req_t       rn [NUM_ISSUE],
    input  wb_req_t       wb [NUM_WB],
    output data_t         data,
    output tag_t          tag
);

    logic rn_hit;

    always_comb begin
        data   = st_data;
        tag    = st_tag;
        rn_hit = 1'b0;
        // Only older slots than the reader may rename under it
        for (int j = 0; j < NUM_ISSUE; j++) begin
            if (j < int'(slot) && rn[j].valid && rn[j].addr == addr) begin
                tag    = rn[j].tag;
                data   = st_data;
                rn_hit = 1'b1;
            end
        end
        if (!rn_hit && st_tag != TAG_READY) begin
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb[k].valid && wb[k].addr == addr && wb[k].tag == st_tag) begin
                    data = wb[k].data;
                    tag  = TAG_READY;
                end
            end
        end
        if (addr == '0) begin
            data = '0;
            tag  = TAG_READY;
        end
    end

endmodule

// File: rtl/tagged_regfile_mp.sv
// Multi-port register file with producer tags, rename/writeback bypass
// and a registered pending-tag count for drain detection.
module tagged_regfile_mp import mips_ss_pkg::*; (
    input logic                clk,
    input logic                reset,
    tagged_regfile_mp_if.slave bus
);

    data_t         data_q [NUM_REGS];
    data_t         data_d [NUM_REGS];
    tag_t          tag_q  [NUM_REGS];
    tag_t          tag_d  [NUM_REGS];
    logic [CW-1:0] pending_q, pending_d;
    logic          all_clear_q, all_clear_d;
    rn_req_t       rn [NUM_ISSUE];
    wb_req_t       wb [NUM_WB];

    always_comb begin
        for (int j = 0; j < NUM_ISSUE; j++) begin
            rn[j] = '{valid: bus.rn_valid[j], addr: bus.rn_addr[j],
                      tag: bus.rn_tag[j]};
        end
        for (int k = 0; k < NUM_WB; k++) begin
            wb[k] = '{valid: bus.wb_valid[k], addr: bus.wb_addr[k],
                      tag: bus.wb_tag[k], data: bus.wb_data[k]};
        end
    end

    // Precedence: wb tag clear < rename < flush
    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb[k].valid && wb[k].addr != '0) begin
                data_d[wb[k].addr] = wb[k].data;
                if (wb[k].tag == tag_q[wb[k].addr]) begin
                    tag_d[wb[k].addr] = TAG_READY;
                end
            end
        end
        if (!bus.flush) begin
            for (int j = 0; j < NUM_ISSUE; j++) begin
                if (rn[j].valid && rn[j].addr != '0) begin
                    tag_d[rn[j].addr] = rn[j].tag;
                end
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                tag_d[i] = TAG_READY;
            end
        end
        data_d[0] = '0;
        tag_d[0]  = TAG_READY;
    end

    always_comb begin
        pending_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pending_d = pending_d + CW'(tag_d[i] != TAG_READY);
        end
        all_clear_d = (pending_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= TAG_READY;
            end
            pending_q   <= '0;
            all_clear_q <= 1'b1;
        end else begin
            data_q      <= data_d;
            tag_q       <= tag_d;
            pending_q   <= pending_d;
            all_clear_q <= all_clear_d;
        end
    end

    assign bus.pending   = pending_q;
    assign bus.all_clear = all_clear_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        tagged_regfile_rdport u_rdport (
            .addr    (bus.rd_addr[p]),
            .slot    (bus.rd_slot[p]),
            .st_data (data_q[bus.rd_addr[p]]),
            .st_tag  (tag_q[bus.rd_addr[p]]),
            .rn      (rn),
            .wb      (wb),
            .data    (bus.rd_data[p]),
            .tag     (bus.rd_tag[p])
        );
    end

endmodule
